// File: rtl/xgmii_pkg.sv
`default_nettype none
// ============================================================================
// Package  : xgmii_pkg
// Purpose  : XGMII control characters, canned words, framer state type and helpers.
// Revision : 1.0
// ============================================================================
package xgmii_pkg;

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERROR = 8'hFE;
    localparam logic [7:0] C_PRE   = 8'h55;
    localparam logic [7:0] C_SFD   = 8'hD5;

    localparam logic [7:0]  C_CTRL_ALL      = 8'hFF;
    localparam logic [63:0] C_IDLE_WORD     = {8{C_IDLE}};
    localparam logic [63:0] C_PREAMBLE_WORD = {C_SFD, {6{C_PRE}}, C_START};
    localparam logic [63:0] C_TERM_WORD     = {{7{C_IDLE}}, C_TERM};
    localparam logic [63:0] C_ERROR_WORD    = {8{C_ERROR}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_ERR  = 3'd2,
        ST_TERM = 3'd3,
        ST_DROP = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

    // Number of consecutive valid lanes starting at lane 0.
    function automatic logic [3:0] lead_ones(input logic [7:0] keep);
        logic [3:0] n;
        logic       run;
        n   = 4'd0;
        run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            run = run & keep[k];
            n   = n + {3'b000, run};
        end
        return n;
    endfunction

    // Idle words still owed after the idle characters already sent in the /T/ word.
    function automatic logic [4:0] gap_words(input int ifg, input int term_idles);
        int rem;
        rem = ifg - term_idles;
        if (rem < 0) rem = 0;
        return 5'((rem + 7) / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xgmii_tx_stats.sv
`default_nettype none
// ============================================================================
// Module   : xgmii_tx_stats
// Purpose  : Wrapping frame / underrun event counters for the XGMII TX framer.
// Revision : 1.0
// ============================================================================
module xgmii_tx_stats (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        frame_done_i,
    input  logic        underrun_i,
    output logic [31:0] frame_cnt_o,
    output logic [31:0] underrun_cnt_o
);
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        frame_cnt_d    = frame_cnt_q + {31'd0, frame_done_i};
        underrun_cnt_d = underrun_cnt_q + {31'd0, underrun_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_cnt_q    <= 32'd0;
            underrun_cnt_q <= 32'd0;
        end else begin
            frame_cnt_q    <= frame_cnt_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign frame_cnt_o    = frame_cnt_q;
    assign underrun_cnt_o = underrun_cnt_q;

endmodule
`default_nettype wire

// File: rtl/xgmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : xgmii_tx_framer
// Purpose  : Lane-0-aligned XGMII TX framer (preamble, data, /T/, minimum IFG).
//            Define XGMII_TX_STATS_EN to add tx_frame_cnt / tx_underrun_cnt.
// Revision : 1.0
// ============================================================================
module xgmii_tx_framer
    import xgmii_pkg::*;
#(
    parameter int IFG_BYTES = 12
) (
    input  logic        xgmii_tx_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] s_tdata,
    input  logic [7:0]  s_tkeep,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc
`ifdef XGMII_TX_STATS_EN
    ,
    output logic [31:0] tx_frame_cnt,
    output logic [31:0] tx_underrun_cnt
`endif
);
    state_t      state_q, state_d;
    logic [4:0]  gap_q, gap_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic        ready_q, ready_d;
    logic [3:0]  keep_run;

    assign keep_run = lead_ones(s_tkeep);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        txd_d   = C_IDLE_WORD;
        txc_d   = C_CTRL_ALL;
        case (state_q)
            // An expired gap is indistinguishable from IDLE, so a start can follow at once.
            ST_IDLE, ST_GAP: begin
                if (state_q == ST_GAP && gap_q != 5'd0) begin
                    gap_d = gap_q - 5'd1;
                end else if (s_tvalid) begin
                    txd_d   = C_PREAMBLE_WORD;
                    txc_d   = 8'h01;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!s_tvalid) begin
                    txd_d   = C_ERROR_WORD;
                    state_d = ST_ERR;
                end else if (!s_tlast || keep_run == 4'd8) begin
                    txd_d   = s_tdata;
                    txc_d   = 8'h00;
                    state_d = s_tlast ? ST_TERM : ST_DATA;
                end else begin
                    for (int k = 0; k < 8; k++) begin
                        if (4'(k) < keep_run) begin
                            txd_d[8*k +: 8] = s_tdata[8*k +: 8];
                            txc_d[k]        = 1'b0;
                        end else if (4'(k) == keep_run) begin
                            txd_d[8*k +: 8] = C_TERM;
                        end
                    end
                    gap_d   = gap_words(IFG_BYTES, 7 - int'(keep_run));
                    state_d = ST_GAP;
                end
            end
            ST_ERR: begin
                txd_d   = C_TERM_WORD;
                state_d = ST_DROP;
            end
            ST_TERM: begin
                txd_d   = C_TERM_WORD;
                gap_d   = gap_words(IFG_BYTES, 7);
                state_d = ST_GAP;
            end
            ST_DROP: begin
                if (s_tvalid && s_tlast) begin
                    gap_d   = gap_words(IFG_BYTES, 0);
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_DATA) || (state_d == ST_DROP);
    end

    always_ff @(posedge xgmii_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= 5'd0;
            txd_q   <= C_IDLE_WORD;
            txc_q   <= C_CTRL_ALL;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            txd_q   <= txd_d;
            txc_q   <= txc_d;
            ready_q <= ready_d;
        end
    end

    assign s_tready  = ready_q;
    assign xgmii_txd = txd_q;
    assign xgmii_txc = txc_q;

`ifdef XGMII_TX_STATS_EN
    logic frame_done;
    logic underrun;

    assign frame_done = (state_d == ST_GAP) && (state_q == ST_DATA || state_q == ST_TERM);
    assign underrun   = (state_q == ST_DATA) && (state_d == ST_ERR);

    xgmii_tx_stats u_stats (
        .clk_i          (xgmii_tx_clk),
        .rst_n_i        (sys_rst_n),
        .frame_done_i   (frame_done),
        .underrun_i     (underrun),
        .frame_cnt_o    (tx_frame_cnt),
        .underrun_cnt_o (tx_underrun_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_xgmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_xgmii_tx_framer
// Purpose  : Self-checking bench: two framers (IFG 12 and IFG 0) against a frame-level model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_xgmii_tx_framer;

    localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] PRE_W  = {8'h01, 64'hD5555555555555FB};
    localparam logic [71:0] TERM_W = {8'hFF, 64'h07070707070707FD};
    localparam logic [71:0] ERR_W  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          gap;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] tdata [2];
    logic [7:0]  tkeep [2];
    logic [1:0]  tvalid;
    logic [1:0]  tlast;
    logic [1:0]  tready;
    logic [63:0] txd [2];
    logic [7:0]  txc [2];
`ifdef XGMII_TX_STATS_EN
    logic [31:0] fcnt [2];
    logic [31:0] ucnt [2];
`endif

    int          tests = 0;
    int          fails = 0;
    int          exp_frames;
    int          exp_underruns;
    logic [71:0] exp_q[$];
    logic [71:0] obs_q[$];
    beat_t       beat_q[$];

    always #5 clk = ~clk;

    xgmii_tx_framer #(.IFG_BYTES(12)) u_dut0 (
        .xgmii_tx_clk (clk),
        .sys_rst_n    (rst_n),
        .s_tdata      (tdata[0]),
        .s_tkeep      (tkeep[0]),
        .s_tvalid     (tvalid[0]),
        .s_tlast      (tlast[0]),
        .s_tready     (tready[0]),
        .xgmii_txd    (txd[0]),
        .xgmii_txc    (txc[0])
`ifdef XGMII_TX_STATS_EN
        ,
        .tx_frame_cnt    (fcnt[0]),
        .tx_underrun_cnt (ucnt[0])
`endif
    );

    xgmii_tx_framer #(.IFG_BYTES(0)) u_dut1 (
        .xgmii_tx_clk (clk),
        .sys_rst_n    (rst_n),
        .s_tdata      (tdata[1]),
        .s_tkeep      (tkeep[1]),
        .s_tvalid     (tvalid[1]),
        .s_tlast      (tlast[1]),
        .s_tready     (tready[1]),
        .xgmii_txd    (txd[1]),
        .xgmii_txc    (txc[1])
`ifdef XGMII_TX_STATS_EN
        ,
        .tx_frame_cnt    (fcnt[1]),
        .tx_underrun_cnt (ucnt[1])
`endif
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Frame-level model: expands one frame into its beats and the XGMII words it must produce.
    task automatic add_frame(input int ifg, input int nb, input logic [7:0] lkeep, input int ur);
        beat_t       bt;
        logic [71:0] w;
        int          n;
        int          ti;
        int          rem;
        exp_q.push_back(PRE_W);
        for (int b = 0; b < nb; b++) begin
            bt.data = {$urandom, $urandom};
            bt.last = (b == nb - 1);
            bt.keep = bt.last ? lkeep : 8'($urandom);
            bt.gap  = (ur > 0 && b == ur) ? 1 : 0;
            beat_q.push_back(bt);
            if (ur > 0) begin
                if (b < ur) exp_q.push_back({8'h00, bt.data});
            end else if (!bt.last) begin
                exp_q.push_back({8'h00, bt.data});
            end else begin
                n = 0;
                while (n < 8 && lkeep[n]) n++;
                if (n == 8) begin
                    exp_q.push_back({8'h00, bt.data});
                    exp_q.push_back(TERM_W);
                    ti = 7;
                end else begin
                    w = IDLE_W;
                    for (int k = 0; k < n; k++) begin
                        w[8*k +: 8] = bt.data[8*k +: 8];
                        w[64 + k]   = 1'b0;
                    end
                    w[8*n +: 8] = 8'hFD;
                    exp_q.push_back(w);
                    ti = 7 - n;
                end
                rem = (ifg > ti) ? ifg - ti : 0;
                repeat ((rem + 7) / 8) exp_q.push_back(IDLE_W);
                exp_frames++;
            end
        end
        if (ur > 0) begin
            exp_q.push_back(ERR_W);
            exp_q.push_back(TERM_W);
            repeat (nb - ur) exp_q.push_back(IDLE_W);
            repeat ((ifg + 7) / 8) exp_q.push_back(IDLE_W);
            exp_underruns++;
        end
    endtask

    task automatic add_random_frame(input int ifg);
        int          nb;
        int          sel;
        int          ur;
        logic [7:0]  lk;
        nb  = $urandom_range(1, 6);
        sel = $urandom_range(0, 3);
        if (sel == 0)      lk = 8'hFF;
        else if (sel == 1) lk = 8'($urandom);
        else               lk = 8'((1 << $urandom_range(0, 7)) - 1);
        ur = (nb >= 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, nb - 1) : 0;
        add_frame(ifg, nb, lk, ur);
    endtask

    task automatic step(input int d, output logic fire);
        @(negedge clk);
        obs_q.push_back({txc[d], txd[d]});
        fire = tvalid[d] & tready[d];
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int d, input string tag);
        beat_t bt;
        logic  fire;
        int    guard;
        obs_q.delete();
        while (beat_q.size() > 0) begin
            bt = beat_q.pop_front();
            for (int g = 0; g < bt.gap; g++) begin
                tvalid[d] = 1'b0;
                step(d, fire);
            end
            tvalid[d] = 1'b1;
            tdata[d]  = bt.data;
            tkeep[d]  = bt.keep;
            tlast[d]  = bt.last;
            guard     = 0;
            do begin
                step(d, fire);
                guard++;
            end while (!fire && guard < 50);
            if (!fire) begin
                tests++;
                fails++;
                $error("FAIL %s_handshake_timeout observed=no_accept expected=accept", tag);
                beat_q.delete();
            end
        end
        tvalid[d] = 1'b0;
        tlast[d]  = 1'b0;
        repeat (30) step(d, fire);
        while (obs_q.size() > 0 && obs_q[0] === IDLE_W) void'(obs_q.pop_front());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), (i < obs_q.size()) ? obs_q[i] : 72'hx, exp_q[i]);
        for (int i = exp_q.size(); i < obs_q.size(); i++)
            check($sformatf("%s_tail%0d", tag, i), obs_q[i], IDLE_W);
        exp_q.delete();
    endtask

    initial begin
        rst_n  = 1'b0;
        tvalid = 2'b00;
        tlast  = 2'b00;
        for (int d = 0; d < 2; d++) begin
            tdata[d] = 64'd0;
            tkeep[d] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_word%0d", d), {txc[d], txd[d]}, IDLE_W);
            check($sformatf("reset_ready%0d", d), {71'd0, tready[d]}, 72'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // IFG 12: full 64-byte frame, n=3, n=7, n=0, underrun after beat 3, then random traffic.
        exp_frames    = 0;
        exp_underruns = 0;
        add_frame(12, 8, 8'hFF, 0);
        add_frame(12, 2, 8'h07, 0);
        add_frame(12, 2, 8'h7F, 0);
        add_frame(12, 1, 8'h00, 0);
        add_frame(12, 6, 8'hFF, 3);
        for (int f = 0; f < 14; f++) add_random_frame(12);
        add_frame(12, 2, 8'hFF, 0);
        run_stream(0, "ifg12");
`ifdef XGMII_TX_STATS_EN
        check("stats_frames0", {40'd0, fcnt[0]}, 72'(exp_frames));
        check("stats_underruns0", {40'd0, ucnt[0]}, 72'(exp_underruns));
`endif

        // IFG 0: back-to-back n=3 frames must abut, plus random traffic.
        exp_frames    = 0;
        exp_underruns = 0;
        add_frame(0, 2, 8'h07, 0);
        add_frame(0, 2, 8'h07, 0);
        add_frame(0, 3, 8'hFF, 0);
        add_frame(0, 4, 8'h01, 2);
        for (int f = 0; f < 12; f++) add_random_frame(0);
        run_stream(1, "ifg0");
`ifdef XGMII_TX_STATS_EN
        check("stats_frames1", {40'd0, fcnt[1]}, 72'(exp_frames));
        check("stats_underruns1", {40'd0, ucnt[1]}, 72'(exp_underruns));
`endif

        // Asynchronous reset while a frame is mid-flight on the IFG 12 framer.
        tdata[0]  = {$urandom, $urandom};
        tkeep[0]  = 8'hFF;
        tlast[0]  = 1'b0;
        tvalid[0] = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_data", {txc[0], txd[0]}, {8'h00, tdata[0]});
        rst_n = 1'b0;
        #1;
        check("async_reset_word", {txc[0], txd[0]}, IDLE_W);
        check("async_reset_ready", {71'd0, tready[0]}, 72'd0);
        tvalid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_frames    = 0;
        exp_underruns = 0;
        add_frame(12, 3, 8'h0F, 0);
        run_stream(0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
